// File: rtl/dft_win_delay.sv
// Circular-buffer sample delay for the sliding-DFT comb stage.
// Emits x[n] with x[n-N], zero-filled until the window is primed.
module dft_win_delay #(
    parameter int DATA_W = 16,
    parameter int ADDR_W = 8
) (
    input  logic              clk,
    input  logic              rst,
    input  logic [ADDR_W:0]   cfg_len,
    input  logic              flush,
    input  logic              s_valid,
    output logic              s_ready,
    input  logic [DATA_W-1:0] s_data,
    output logic              m_valid,
    input  logic              m_ready,
    output logic [DATA_W-1:0] m_new,
    output logic [DATA_W-1:0] m_old,
    output logic              m_primed
);

    localparam int DEPTH = 1 << ADDR_W;
    localparam logic [ADDR_W:0] LEN_MAX = (ADDR_W+1)'(DEPTH);
    localparam logic [ADDR_W:0] LEN_MIN = (ADDR_W+1)'(1);

    logic [DATA_W-1:0] mem [DEPTH];
    logic [DATA_W-1:0] rd_q;
    logic [ADDR_W:0]   len_q;
    logic [ADDR_W:0]   len_d;
    logic [ADDR_W:0]   fill;
    logic [ADDR_W-1:0] wptr;
    logic [ADDR_W-1:0] rptr;
    logic              clr;
    logic              acc;

    assign clr     = rst || flush;
    assign s_ready = !clr && (!m_valid || m_ready);
    assign acc     = s_valid && s_ready;
    // len_q == DEPTH_MAX folds to rptr == wptr
    assign rptr    = wptr - len_q[ADDR_W-1:0];
    assign m_old   = m_primed ? rd_q : '0;

    always_comb begin
        len_d = cfg_len;
        if (cfg_len == '0) begin
            len_d = LEN_MIN;
        end else if (cfg_len > LEN_MAX) begin
            len_d = LEN_MAX;
        end
    end

    // Read-before-write: the read sees the old word even when rptr == wptr
    always_ff @(posedge clk) begin
        if (acc) begin
            mem[wptr] <= s_data;
            rd_q      <= mem[rptr];
        end
    end

    always_ff @(posedge clk) begin
        if (clr) begin
            len_q    <= len_d;
            wptr     <= '0;
            fill     <= '0;
            m_valid  <= 1'b0;
            m_primed <= 1'b0;
            if (rst) begin
                m_new <= '0;
            end
        end else begin
            if (acc) begin
                wptr     <= wptr + 1'b1;
                m_new    <= s_data;
                m_primed <= (fill == len_q);
                m_valid  <= 1'b1;
                if (fill != len_q) begin
                    fill <= fill + 1'b1;
                end
            end else if (m_valid && m_ready) begin
                m_valid <= 1'b0;
            end
        end
    end

endmodule
